// File: rtl/btb_2way_predictor.sv
// Fetch-stage branch predictor: 2-way set-associative BTB with per-set LRU.
// Direction comes from per-entry counters (MODE 0) or a gshare PHT (MODE 1).
module btb_2way_predictor #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int MODE  = 0,
    parameter int GHR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instructionPC_1,
    output logic [31:0]      branchPC,
    output logic             taken,
    output logic             flush,
    output logic [GHR_W-1:0] pht_idx_1,
    input  logic [31:0]      instructionPC_3,
    input  logic             is_branchInst_3,
    input  logic             taken_3,
    input  logic [31:0]      target_3,
    input  logic             prev_taken_3,
    input  logic [31:0]      prev_target_3,
    input  logic [GHR_W-1:0] pht_idx_3
);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PHT_N = 1 << GHR_W;

    logic             valid_reg  [2][SETS];
    logic [TAG_W-1:0] tag_reg    [2][SETS];
    logic [31:0]      target_reg [2][SETS];
    logic [1:0]       ctr_reg    [2][SETS];
    logic             lru_reg    [SETS];
    logic [GHR_W-1:0] ghr_reg;
    logic [1:0]       pht_reg    [PHT_N];

    logic [IDX_W-1:0] idx_1, idx_3;
    logic [TAG_W-1:0] tag_1, tag_3;
    logic [1:0]       hit_way_1, hit_way_3;
    logic             hit_1, hit_3;
    logic             way_1, way_3, victim_3;
    logic             pred_taken_1;
    logic [GHR_W-1:0] pht_idx_int;
    logic             mis;
    logic [31:0]      redirect;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign idx_1 = instructionPC_1[IDX_W+1:2];
    assign tag_1 = instructionPC_1[31:IDX_W+2];
    assign idx_3 = instructionPC_3[IDX_W+1:2];
    assign tag_3 = instructionPC_3[31:IDX_W+2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_way
        assign hit_way_1[gi] = valid_reg[gi][idx_1] && (tag_reg[gi][idx_1] == tag_1);
        assign hit_way_3[gi] = valid_reg[gi][idx_3] && (tag_reg[gi][idx_3] == tag_3);
    end

    // A double match cannot be created by allocation; way 0 wins if it ever occurs.
    assign hit_1 = |hit_way_1;
    assign way_1 = ~hit_way_1[0];
    assign hit_3 = |hit_way_3;
    assign way_3 = ~hit_way_3[0];

    assign victim_3 = !valid_reg[0][idx_3] ? 1'b0 :
                      !valid_reg[1][idx_3] ? 1'b1 : lru_reg[idx_3];

    assign pht_idx_int  = instructionPC_1[GHR_W+1:2] ^ ghr_reg;
    assign pht_idx_1    = pht_idx_int;
    assign pred_taken_1 = hit_1 & ((MODE == 1) ? pht_reg[pht_idx_int][1]
                                               : ctr_reg[way_1][idx_1][1]);

    assign mis = is_branchInst_3 &
                 ((prev_taken_3 != taken_3) | (taken_3 & (prev_target_3 != target_3)));
    assign redirect = taken_3 ? target_3 : instructionPC_3 + 32'd4;

    always_comb begin
        flush    = 1'b0;
        taken    = pred_taken_1;
        branchPC = pred_taken_1 ? target_reg[way_1][idx_1] : instructionPC_1 + 32'd4;
        if (mis) begin
            flush    = 1'b1;
            taken    = 1'b0;
            branchPC = redirect;
        end
    end

    // Stage-1 reads see pre-update contents; resolve writes land on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                lru_reg[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    valid_reg[w][s]  <= 1'b0;
                    tag_reg[w][s]    <= '0;
                    target_reg[w][s] <= '0;
                    ctr_reg[w][s]    <= 2'b00;
                end
            end
            ghr_reg <= '0;
            for (int p = 0; p < PHT_N; p++) begin
                pht_reg[p] <= 2'b01;
            end
        end else if (is_branchInst_3) begin
            if (hit_3) begin
                ctr_reg[way_3][idx_3] <= ctr_step(ctr_reg[way_3][idx_3], taken_3);
                if (taken_3) begin
                    target_reg[way_3][idx_3] <= target_3;
                end
                lru_reg[idx_3] <= ~way_3;
            end else if (taken_3) begin
                valid_reg[victim_3][idx_3]  <= 1'b1;
                tag_reg[victim_3][idx_3]    <= tag_3;
                target_reg[victim_3][idx_3] <= target_3;
                ctr_reg[victim_3][idx_3]    <= 2'b10;
                lru_reg[idx_3]              <= ~victim_3;
            end
            if (MODE == 1) begin
                pht_reg[pht_idx_3] <= ctr_step(pht_reg[pht_idx_3], taken_3);
                ghr_reg            <= {ghr_reg[GHR_W-2:0], taken_3};
            end
        end
    end
endmodule

// File: tb/tb_btb_2way_predictor.sv
// Bench for btb_2way_predictor: bimodal instance driven from a vector table,
// gshare instance (GHR_W=2) driven by a resolve loop, plus an async-reset sequence.
module tb_btb_2way_predictor;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] pc1_a, pc3_a, tgt3_a, ptgt3_a, bpc_a;
    logic        br_a, t3_a, pt3_a, taken_a, flush_a;
    logic [5:0]  pidx1_a, pidx3_a;

    logic [31:0] pc1_b, pc3_b, tgt3_b, ptgt3_b, bpc_b;
    logic        br_b, t3_b, pt3_b, taken_b, flush_b;
    logic [1:0]  pidx1_b, pidx3_b;

    btb_2way_predictor #(.SETS(8), .IDX_W(3), .MODE(0), .GHR_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .instructionPC_1(pc1_a), .branchPC(bpc_a),
        .taken(taken_a), .flush(flush_a), .pht_idx_1(pidx1_a),
        .instructionPC_3(pc3_a), .is_branchInst_3(br_a), .taken_3(t3_a),
        .target_3(tgt3_a), .prev_taken_3(pt3_a), .prev_target_3(ptgt3_a),
        .pht_idx_3(pidx3_a));

    btb_2way_predictor #(.SETS(8), .IDX_W(3), .MODE(1), .GHR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .instructionPC_1(pc1_b), .branchPC(bpc_b),
        .taken(taken_b), .flush(flush_b), .pht_idx_1(pidx1_b),
        .instructionPC_3(pc3_b), .is_branchInst_3(br_b), .taken_3(t3_b),
        .target_3(tgt3_b), .prev_taken_3(pt3_b), .prev_target_3(ptgt3_b),
        .pht_idx_3(pidx3_b));

    typedef struct {
        logic [31:0] pc1;
        logic        br;
        logic [31:0] pc3;
        logic        t3;
        logic [31:0] tgt3;
        logic        pt3;
        logic [31:0] ptgt3;
        logic        exp_taken;
        logic        exp_flush;
        logic [31:0] exp_bpc;
    } vec_t;

    typedef struct {
        logic        taken;
        logic        flush;
        logic [31:0] bpc;
        logic [1:0]  idx;
        bit          chk_idx;
    } exp_t;

    vec_t vt[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic [31:0] pc1, input logic br, input logic [31:0] pc3,
                                input logic t3, input logic [31:0] tgt3, input logic pt3,
                                input logic [31:0] ptgt3, input logic et, input logic ef,
                                input logic [31:0] eb);
        vec_t v;
        v.pc1 = pc1; v.br = br; v.pc3 = pc3; v.t3 = t3; v.tgt3 = tgt3;
        v.pt3 = pt3; v.ptgt3 = ptgt3; v.exp_taken = et; v.exp_flush = ef; v.exp_bpc = eb;
        return v;
    endfunction

    task automatic check(input bit sel, input int id);
        exp_t        e;
        logic        tk, fl;
        logic [31:0] bp;
        logic [1:0]  ix;
        n_vec++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL vec%0d scoreboard empty: got no expectation, required one", id);
            return;
        end
        e  = sb_q.pop_front();
        tk = sel ? taken_b : taken_a;
        fl = sel ? flush_b : flush_a;
        bp = sel ? bpc_b : bpc_a;
        ix = pidx1_b;
        $display("vec %0d dut%0d taken=%b flush=%b branchPC=%h", id, sel, tk, fl, bp);
        if (tk !== e.taken) begin
            miscompares++;
            $display("FAIL vec%0d taken: got %b required %b", id, tk, e.taken);
        end
        if (fl !== e.flush) begin
            miscompares++;
            $display("FAIL vec%0d flush: got %b required %b", id, fl, e.flush);
        end
        if (bp !== e.bpc) begin
            miscompares++;
            $display("FAIL vec%0d branchPC: got %h required %h", id, bp, e.bpc);
        end
        if (e.chk_idx && ix !== e.idx) begin
            miscompares++;
            $display("FAIL vec%0d pht_idx_1: got %0d required %0d", id, ix, e.idx);
        end
    endtask

    task automatic push_exp(input logic t, input logic f, input logic [31:0] b,
                            input logic [1:0] ix, input bit ci);
        exp_t e;
        e.taken = t; e.flush = f; e.bpc = b; e.idx = ix; e.chk_idx = ci;
        sb_q.push_back(e);
    endtask

    task automatic apply0(input vec_t v, input int id);
        @(posedge clk);
        #1;
        pc1_a = v.pc1; br_a = v.br; pc3_a = v.pc3; t3_a = v.t3;
        tgt3_a = v.tgt3; pt3_a = v.pt3; ptgt3_a = v.ptgt3;
        push_exp(v.exp_taken, v.exp_flush, v.exp_bpc, 2'b00, 1'b0);
        @(negedge clk);
        check(1'b0, id);
    endtask

    logic [1:0] idx_t [10] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic       pred_t[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        pc1_a = 32'h100; br_a = 0; pc3_a = 0; t3_a = 0; tgt3_a = 0; pt3_a = 0; ptgt3_a = 0; pidx3_a = 0;
        pc1_b = 32'h300; br_b = 0; pc3_b = 0; t3_b = 0; tgt3_b = 0; pt3_b = 0; ptgt3_b = 0; pidx3_b = 0;

        //        pc1            br pc3           t3 tgt3          pt3 ptgt3        taken flush branchPC
        vt.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h104));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 1, 32'h200));
        vt.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h200));
        vt.push_back(mk(32'h18C, 1, 32'h18C, 1, 32'h300, 1, 32'h300, 0, 0, 32'h190));
        vt.push_back(mk(32'h18C, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h300));
        vt.push_back(mk(32'h100, 1, 32'h120, 1, 32'h220, 0, 32'h124, 0, 1, 32'h220));
        vt.push_back(mk(32'h120, 1, 32'h140, 1, 32'h240, 0, 32'h144, 0, 1, 32'h240));
        vt.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h104));
        vt.push_back(mk(32'h120, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h220));
        vt.push_back(mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h240));
        vt.push_back(mk(32'h140, 1, 32'h120, 0, 32'h0,   1, 32'h220, 0, 1, 32'h124));
        vt.push_back(mk(32'h120, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h124));
        vt.push_back(mk(32'h120, 1, 32'h140, 1, 32'h260, 1, 32'h240, 0, 1, 32'h260));
        vt.push_back(mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h260));
        vt.push_back(mk(32'h140, 1, 32'h1A0, 0, 32'h0,   0, 32'h1A4, 1, 0, 32'h260));
        vt.push_back(mk(32'h1A0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h1A4));
        vt.push_back(mk(32'h120, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h124));
        vt.push_back(mk(32'h140, 0, 32'h500, 0, 32'h0,   1, 32'h999, 1, 0, 32'h260));
        vt.push_back(mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h0, 0, 1, 32'h0));
        vt.push_back(mk(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 1, 32'h120, 0, 32'h0,   0, 32'h124, 0, 0, 32'h104));
        vt.push_back(mk(32'h100, 1, 32'h120, 0, 32'h0,   0, 32'h124, 0, 0, 32'h104));
        vt.push_back(mk(32'h100, 1, 32'h120, 1, 32'h220, 0, 32'h124, 0, 1, 32'h220));
        vt.push_back(mk(32'h100, 1, 32'h120, 1, 32'h220, 0, 32'h124, 0, 1, 32'h220));
        vt.push_back(mk(32'h120, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h220));
        vt.push_back(mk(32'h100, 1, 32'h140, 1, 32'h260, 1, 32'h260, 0, 0, 32'h104));
        vt.push_back(mk(32'h100, 1, 32'h140, 0, 32'h0,   0, 32'h144, 0, 0, 32'h104));
        vt.push_back(mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h260));

        #12 rst_n = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            apply0(vt[i], i);
        end

        // Async reset asserted while an allocation is pending on the next edge.
        @(posedge clk);
        #1;
        pc1_a = 32'h140; br_a = 1; pc3_a = 32'h1D4; t3_a = 1; tgt3_a = 32'h2D4;
        pt3_a = 1; ptgt3_a = 32'h2D4;
        #2 rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 32'h144, 2'b00, 1'b0);
        check(1'b0, 100);
        @(posedge clk);
        #1;
        br_a = 0;
        rst_n = 1'b1;
        apply0(mk(32'h1D4, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h1D8), 101);
        apply0(mk(32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h144), 102);

        // gshare: alternating T/N at 0x300, lookup then resolve for each branch.
        for (int i = 0; i < 10; i++) begin
            logic        t, p, m;
            logic [31:0] pb;
            t  = (i % 2 == 0);
            p  = pred_t[i];
            pb = p ? 32'h380 : 32'h304;
            @(posedge clk);
            #1;
            pc1_b = 32'h300; br_b = 0;
            push_exp(p, 1'b0, pb, idx_t[i], 1'b1);
            @(negedge clk);
            check(1'b1, 200 + 2 * i);
            @(posedge clk);
            #1;
            br_b = 1; pc3_b = 32'h300; t3_b = t; tgt3_b = 32'h380;
            pt3_b = p; ptgt3_b = pb; pidx3_b = idx_t[i];
            m = (p != t) | (t & (pb != 32'h380));
            if (m)
                push_exp(1'b0, 1'b1, t ? 32'h380 : 32'h304, idx_t[i], 1'b1);
            else
                push_exp(p, 1'b0, pb, idx_t[i], 1'b1);
            @(negedge clk);
            check(1'b1, 201 + 2 * i);
        end
        @(posedge clk);
        #1 br_b = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule

// File: doc/btb_2way_predictor.md
Name: btb_2way_predictor

Overview:
- Parametrised successor to the fetch-stage branch target buffer.
- Replaces the direct-mapped table with a 2-way set-associative BTB (per-set LRU).
- Direction prediction is selectable: per-entry 2-bit counters (bimodal) or a gshare pattern history table indexed by PC XOR global history.
- Predicts in stage 1 (fetch) and is corrected/updated in stage 3 (branch resolve); drives next-PC select and pipeline flush.

Parameters:
- SETS, 8: number of sets; power of 2, >=2.
- IDX_W, 3: log2(SETS).
- MODE, 0: 0 = bimodal (counter in BTB entry); 1 = gshare (counter in PHT).
- GHR_W, 6: global history length; PHT has 2^GHR_W entries; used only when MODE=1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- instructionPC_1  input  32  fetch PC to predict.
- branchPC  output  32  next fetch PC: predicted target, PC+4, or redirect.
- taken  output  1  stage-1 predicted taken.
- flush  output  1  stage-3 mispredict; flush stages 1-2.
- pht_idx_1  output  GHR_W  PHT index used for this prediction; piped to stage 3.
- instructionPC_3  input  32  PC of the resolving instruction.
- is_branchInst_3  input  1  stage-3 instruction is a branch/jump.
- taken_3  input  1  resolved direction.
- target_3  input  32  resolved taken target.
- prev_taken_3  input  1  stage-1 taken, piped.
- prev_target_3  input  32  stage-1 branchPC, piped.
- pht_idx_3  input  GHR_W  pht_idx_1, piped.

Behaviour:
- Addressing:
  - index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].
  - Entry fields: valid, tag, target[31:0], ctr[1:0]. One LRU bit per set; LRU=w means way w is next victim.
- Lookup (combinational on registered state):
  - hit_1 = a way in set index(PC_1) is valid with tag match.
  - MODE 0: predicted taken = hit_1 & ctr_way[1].
  - MODE 1: pht_idx_1 = PC_1[GHR_W+1:2] ^ ghr; predicted taken = hit_1 & pht[pht_idx_1][1].
  - pht_idx_1 is driven in both modes; it is a don't-care in MODE 0.
  - Both ways matching cannot arise, since allocation checks both ways; if it does, way 0 wins.
- Mispredict:
  - mis = is_branchInst_3 & ((prev_taken_3 != taken_3) | (taken_3 & prev_target_3 != target_3)).
  - redirect = taken_3 ? target_3 : instructionPC_3+4, 32-bit wrap.
- Output priority:
  - If mis: flush=1, branchPC=redirect, taken=0.
  - Else: flush=0, branchPC = predicted taken ? hit target : PC_1+4, taken = prediction.
- Update, at posedge, only when is_branchInst_3:
  - Hit, way w: ctr saturates (00<->01<->10<->11, +1 if taken_3, -1 otherwise); if taken_3, target<=target_3; LRU<=~w.
  - Miss with taken_3: victim = first invalid way (way 0 first), else the LRU way. Write valid=1, tag, target_3, ctr=2'b10; LRU<=~victim.
  - Miss with not taken: no allocation, no LRU change.
  - MODE 1: pht[pht_idx_3] updates saturating on every branch; ghr <= {ghr[GHR_W-2:0], taken_3}. History is non-speculative (resolve only).
- Same-set collision: a stage-1 lookup in the set being updated sees the pre-update contents; no bypass. Writes land next cycle.
- Reset (async, any time, including mid-update):
  - All valid=0, ctr=00, LRU=0, ghr=0, all PHT entries=2'b01.
  - Outputs are combinational, so with cleared tables and is_branchInst_3=0: taken=0, flush=0, branchPC=instructionPC_1+4.
- Storage and timing:
  - Flops only; no memory macros. One state update per cycle.
  - Zero-cycle prediction latency; one-cycle update latency.

Test Plan:
- Reset, PC_1=0x100 -> taken=0, branchPC=0x104, flush=0; table all invalid.
- Resolve branch at 0x100, taken_3=1, target_3=0x200, prev_taken_3=0 -> flush=1, branchPC=0x200. Next cycle PC_1=0x100 -> taken=1, branchPC=0x200 (ctr=10).
- SETS=8, taken branches at 0x100, 0x120, 0x140 (same set 0). The third allocates into the LRU way, evicting 0x100 -> lookup 0x100 misses, 0x120 and 0x140 hit.
- Entry at ctr=10, resolve not-taken with prev_taken_3=1 -> flush=1, branchPC=PC_3+4, ctr=01. Next lookup predicts not-taken.
- MODE=1, GHR_W=2, alternating T/N branch at 0x300 for 8 resolutions -> after warm-up, taken tracks the pattern with no flushes; saturation 11+taken stays 11.
- Assert rst_n low in the same cycle as an update -> no entry written; all state cleared; taken=0.
